i2c_target_regfile: RTL

Parametrised I2C target with an internal register file, the next generation of the `i2c_top` subordinate. It decodes START/STOP/repeated-START on oversampled SCL/SDA, matches a parametrised 7-bit device address, takes a full 8-bit register pointer, and supports multi-byte writes and reads with pointer auto-increment and wrap. A parallel host port gives the rest of the FPGA design, such as LED or control logic, access to the same registers. An optional clock-stretch feature is also provided.

---
 rtl/i2c_pkg.sv | 9 +
 rtl/i2c_line_sync.sv | 26 ++
 rtl/i2c_target_regfile.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bus constants for the I2C target.
package i2c_pkg;
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE
    } i2c_state_t;
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam int   RW_BIT   = 0;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchroniser for one open-drain line with rise/fall pulses.
module i2c_line_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    logic prev;
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync <= '1;
            prev <= 1'b1;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end
    assign q    = sync[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target with host-accessible register file; I2C_CLK_STRETCH_EN adds clock stretching.
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h66,
    parameter int         REG_DEPTH   = 16,
    parameter int         PTR_W       = $clog2(REG_DEPTH),
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             scl_oe,
    output logic             sda_oe,
    input  logic [PTR_W-1:0] host_addr,
    input  logic [7:0]       host_wdata,
    input  logic             host_we,
    output logic [7:0]       host_rdata,
`ifdef I2C_CLK_STRETCH_EN
    input  logic             stretch_req,
`endif
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy
);
    logic scl_q, scl_rise, scl_fall, sda_q, sda_rise, sda_fall;
    logic start_c, stop_c, i2c_we;
    i2c_state_t state;
    logic [7:0] sr, rd_byte;
    logic [3:0] cnt;
    logic [PTR_W-1:0] ptr;
    logic rw, mack;
    logic [7:0] regs [REG_DEPTH];

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl (
        .clk(clk), .rst(rst), .d(scl_i), .q(scl_q), .rise(scl_rise), .fall(scl_fall)
    );
    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda (
        .clk(clk), .rst(rst), .d(sda_i), .q(sda_q), .rise(sda_rise), .fall(sda_fall)
    );

    assign start_c = scl_q & sda_fall;
    assign stop_c  = scl_q & sda_rise;
    assign rd_byte = regs[ptr];
    assign i2c_we  = state == WR && scl_fall && cnt == 4'd8 && !start_c && !stop_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            mack      <= I2C_NACK;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_strobe <= i2c_we;
            if (i2c_we) begin
                wr_addr <= ptr;
                wr_data <= sr;
            end
            if (start_c) begin
                state  <= ADDR;
                cnt    <= '0;
                busy   <= 1'b1;
                sda_oe <= 1'b0;
            end else if (stop_c) begin
                state  <= IDLE;
                busy   <= 1'b0;
                sda_oe <= 1'b0;
            end else if (scl_rise) begin
                if (state == ADDR || state == PTR || state == WR) begin
                    sr  <= {sr[6:0], sda_q};
                    cnt <= cnt + 4'd1;
                end else if (state == RD) begin
                    cnt <= cnt + 4'd1;
                end else if (state == RD_ACK) begin
                    mack <= sda_q;
                end
            end else if (scl_fall) begin
                case (state)
                    ADDR: if (cnt == 4'd8) begin
                        state  <= sr[7:1] == DEV_ADDR ? ADDR_ACK : IGNORE;
                        sda_oe <= sr[7:1] == DEV_ADDR;
                        rw     <= sr[RW_BIT];
                    end
                    ADDR_ACK: begin
                        state  <= rw ? RD : PTR;
                        cnt    <= '0;
                        sda_oe <= rw & ~rd_byte[7];
                        if (rw) begin
                            sr  <= rd_byte;
                            ptr <= ptr + PTR_W'(1);
                        end
                    end
                    PTR: if (cnt == 4'd8) begin
                        if ({1'b0, sr} >= 9'(REG_DEPTH)) begin
                            state <= IGNORE;
                        end else begin
                            ptr    <= sr[PTR_W-1:0];
                            state  <= PTR_ACK;
                            sda_oe <= ~I2C_ACK;
                        end
                    end
                    PTR_ACK: begin
                        state  <= WR;
                        cnt    <= '0;
                        sda_oe <= 1'b0;
                    end
                    WR: if (cnt == 4'd8) begin
                        state  <= WR_ACK;
                        sda_oe <= ~I2C_ACK;
                    end
                    WR_ACK: begin
                        state  <= WR;
                        cnt    <= '0;
                        sda_oe <= 1'b0;
                        ptr    <= ptr + PTR_W'(1);
                    end
                    RD: if (cnt == 4'd8) begin
                        state  <= RD_ACK;
                        sda_oe <= 1'b0;
                    end else begin
                        sr     <= {sr[6:0], 1'b0};
                        sda_oe <= ~sr[6];
                    end
                    RD_ACK: if (mack == I2C_ACK) begin
                        state  <= RD;
                        cnt    <= '0;
                        sr     <= rd_byte;
                        ptr    <= ptr + PTR_W'(1);
                        sda_oe <= ~rd_byte[7];
                    end else begin
                        state  <= IGNORE;
                        sda_oe <= 1'b0;
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end

    // I2C write is ordered last so it wins a same-cycle collision with the host.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
            host_rdata <= '0;
        end else begin
            if (host_we) regs[host_addr] <= host_wdata;
            if (i2c_we) regs[ptr] <= sr;
            host_rdata <= regs[host_addr];
        end
    end

`ifdef I2C_CLK_STRETCH_EN
    always_ff @(posedge clk) begin
        if (!rst) scl_oe <= 1'b0;
        else scl_oe <= stretch_req & ~scl_q;
    end
`else
    assign scl_oe = 1'b0;
`endif
endmodule
